cur_mb_loader: RTL and testbench
================================

# cur_mb_loader

Fetches the current macroblock's pixels from external frame memory into the encoder's cur_mb buffer: 16×16 luma and 8×8 Cb/Cr, planar 4:2:0. It sits directly downstream of the encoder top controller's load handshake. It starts on that controller's load_start pulse for the macroblock at (mb_x, mb_y). It reports completion on a level done signal, which the controller edge-detects.

## Interface
- PIC_W_MB_LEN, 8, width of macroblock x index / x total
- PIC_H_MB_LEN, 8, width of macroblock y index
- ADDR_W, 32, byte address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_start_i  in  1  one-cycle start pulse
- mb_x_i  in  PIC_W_MB_LEN  macroblock column, sampled on start
- mb_y_i  in  PIC_H_MB_LEN  macroblock row, sampled on start
- sys_x_total_i  in  PIC_W_MB_LEN  macroblocks per row minus 1, sampled on start
- y_base_i / u_base_i / v_base_i  in  ADDR_W  plane base byte addresses, sampled on start
- load_done_o  out  1  high = current macroblock fully written
- rd_req_o  out  1  row read request
- rd_addr_o  out  ADDR_W  row start byte address
- rd_beats_o  out  2  beats in this request: 2 for luma, 1 for chroma
- rd_ack_i  in  1  request accepted
- rd_valid_i  in  1  read data beat valid
- rd_data_i  in  64  8 pixels; byte 0 = lowest address
- buf_wr_en_o  out  1  cur_mb buffer write strobe
- buf_wr_addr_o  out  6  buffer word address
- buf_wr_data_o  out  64  buffer write data

## Operation
- States: IDLE, REQ, DATA, DONE. Internal plane register (Y, U, V), 4-bit row counter, 1-bit beat counter.
- IDLE/DONE + load_start_i: latch all inputs, clear load_done_o, set plane = Y and row = 0, then go to REQ.
- load_start_i in REQ or DATA is ignored.
- REQ: drive rd_req_o with rd_addr_o and rd_beats_o held stable. On rd_ack_i (same-cycle ack allowed), go to DATA.
- DATA: each rd_valid_i writes one buffer word and increments the beat counter. rd_valid_i in any other state is ignored.
- On the last beat of a row, advance the row counter and return to REQ.
- Row sequence: Y rows 0–15, then U rows 0–7, then V rows 0–7.
- After V row 7 completes, go to DONE with load_done_o = 1.
- Only one request is outstanding at a time.
- Strides: lstride = (sys_x_total_i+1)·16, cstride = (sys_x_total_i+1)·8.
- Luma address = y_base + (mb_y·16 + row)·lstride + mb_x·16.
- Chroma address = {u|v}_base + (mb_y·8 + row)·cstride + mb_x·8.
- All address arithmetic is unsigned and truncated modulo 2^ADDR_W.
- Buffer map:
  - Luma row r, beat b → 2r + b (0–31); beat 0 = pixels 0–7.
  - U row r → 32 + r.
  - V row r → 40 + r.
  - Addresses 48–63 are never written.
- buf_wr_data_o = rd_data_i, registered.

## Timing
- Reset values: load_done_o = 0, rd_req_o = 0, rd_addr_o = 0, rd_beats_o = 0, buf_wr_en_o = 0, buf_wr_addr_o = 0, buf_wr_data_o = 0; state = IDLE.
- load_done_o resets to 0 so that reset release produces no rising edge.
- Start sampled at the edge ending cycle T:
  - load_done_o is low and rd_req_o is high from cycle T+1.
  - If load_done_o was already low, it stays low.
- buf_wr_en_o is asserted the cycle after the rd_valid_i beat (registered write).
- load_done_o rises in the cycle after the final V beat's buf_wr_en_o. It stays high until the next accepted start.
- Zero-wait memory case (ack in the REQ cycle, a beat in every DATA cycle):
  - Luma row = 3 cycles, chroma row = 2 cycles.
  - 80 cycles of REQ/DATA, so load_done_o is high from cycle T+82.
- Back-to-back: a start in the same cycle load_done_o is high is accepted, and load_done_o falls the next cycle. This gives one clean rising edge per macroblock.
- Reset mid-operation: immediate return to IDLE with reset values. No partial done is reported. An in-flight request is abandoned and the memory side must be reset with it.
- Wrap: sys_x_total_i = 255 with mb_x = 255 gives mb_x·16 = 4080 with no overflow at ADDR_W = 32. Sums exceeding ADDR_W wrap silently.

## Test plan
- Single macroblock, sys_x_total = 1, mb (0,0), bases 0x1000/0x2000/0x3000, zero-wait memory:
  - rd_addr sequence is 0x1000, 0x1020, …, 0x11E0, then 0x2000, 0x2010, …, 0x2070, then 0x3000, …, 0x3070.
  - 48 writes to addresses 0–47; load_done_o rises at T+82.
- mb (1,1), sys_x_total = 1: first luma address = 0x1000 + 16·32 + 16 = 0x1210; first U address = 0x2000 + 8·16 + 8 = 0x2088.
- Backpressure: rd_ack delayed 3 cycles and rd_valid gapped randomly. rd_addr_o/rd_beats_o must stay stable while rd_req_o is high; write count and data match a reference model.
- Spurious inputs: load_start pulsed mid-transfer and rd_valid pulsed in REQ/IDLE. No extra request, no extra write, done timing unchanged.
- Back-to-back macroblocks: a start on the first cycle done is high makes load_done_o low for ≥1 cycle, and each macroblock yields exactly one rising edge.
- rst_n asserted during U row 3: all outputs 0 next cycle. A fresh start afterwards completes normally from Y row 0.

Source files
------------

// File: rtl/cur_mb_loader.sv
// Current-macroblock loader: fetches 16x16 luma and 8x8 Cb/Cr rows from frame
// memory, one outstanding row request at a time, into the cur_mb buffer.
module cur_mb_loader #(
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8,
    parameter int ADDR_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start_i,
    input  logic [PIC_W_MB_LEN-1:0] mb_x_i,
    input  logic [PIC_H_MB_LEN-1:0] mb_y_i,
    input  logic [PIC_W_MB_LEN-1:0] sys_x_total_i,
    input  logic [ADDR_W-1:0]       y_base_i,
    input  logic [ADDR_W-1:0]       u_base_i,
    input  logic [ADDR_W-1:0]       v_base_i,
    output logic                    load_done_o,
    output logic                    rd_req_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    output logic [1:0]              rd_beats_o,
    input  logic                    rd_ack_i,
    input  logic                    rd_valid_i,
    input  logic [63:0]             rd_data_i,
    output logic                    buf_wr_en_o,
    output logic [5:0]              buf_wr_addr_o,
    output logic [63:0]             buf_wr_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;
    typedef enum logic [1:0] {PL_Y, PL_U, PL_V} plane_t;

    state_t                  r_state;
    plane_t                  r_plane;
    logic [3:0]              r_row;
    logic                    r_beat;
    logic [PIC_W_MB_LEN-1:0] r_mb_x;
    logic [PIC_H_MB_LEN-1:0] r_mb_y;
    logic [PIC_W_MB_LEN-1:0] r_x_total;
    logic [ADDR_W-1:0]       r_y_base;
    logic [ADDR_W-1:0]       r_u_base;
    logic [ADDR_W-1:0]       r_v_base;

    plane_t                  w_nxt_plane;
    logic [3:0]              w_nxt_row;
    logic                    w_last_beat;
    logic                    w_row_last;
    logic                    w_fin;
    logic [5:0]              w_wr_addr;
    logic [ADDR_W-1:0]       w_start_addr;
    logic [ADDR_W-1:0]       w_nxt_addr;

    // Row start address; luma scales by 16 pixels per MB, chroma by 8.
    function automatic logic [ADDR_W-1:0] f_row_addr(
        input plane_t                  pl,
        input logic [3:0]              row,
        input logic [PIC_W_MB_LEN-1:0] mx,
        input logic [PIC_H_MB_LEN-1:0] my,
        input logic [PIC_W_MB_LEN-1:0] xt,
        input logic [ADDR_W-1:0]       yb,
        input logic [ADDR_W-1:0]       ub,
        input logic [ADDR_W-1:0]       vb
    );
        logic [ADDR_W-1:0] w_stride, w_line, w_col, w_base;
        if (pl == PL_Y) begin
            w_stride = (ADDR_W'(xt) + ADDR_W'(1)) << 4;
            w_line   = (ADDR_W'(my) << 4) + ADDR_W'(row);
            w_col    = ADDR_W'(mx) << 4;
            w_base   = yb;
        end else begin
            w_stride = (ADDR_W'(xt) + ADDR_W'(1)) << 3;
            w_line   = (ADDR_W'(my) << 3) + ADDR_W'(row);
            w_col    = ADDR_W'(mx) << 3;
            w_base   = (pl == PL_U) ? ub : vb;
        end
        return w_base + w_line * w_stride + w_col;
    endfunction

    always_comb begin
        w_last_beat = (r_plane == PL_Y) ? r_beat : 1'b1;
        w_row_last  = (r_plane == PL_Y) ? (r_row == 4'd15) : (r_row == 4'd7);
        w_fin       = w_row_last && (r_plane == PL_V);
        w_nxt_plane = r_plane;
        w_nxt_row   = r_row + 4'd1;
        if (w_row_last) begin
            w_nxt_row   = 4'd0;
            w_nxt_plane = (r_plane == PL_Y) ? PL_U : PL_V;
        end
        case (r_plane)
            PL_Y:    w_wr_addr = {1'b0, r_row, r_beat};
            PL_U:    w_wr_addr = {3'b100, r_row[2:0]};
            default: w_wr_addr = {3'b101, r_row[2:0]};
        endcase
    end

    assign w_start_addr = f_row_addr(PL_Y, 4'd0, mb_x_i, mb_y_i, sys_x_total_i,
                                     y_base_i, u_base_i, v_base_i);
    assign w_nxt_addr   = f_row_addr(w_nxt_plane, w_nxt_row, r_mb_x, r_mb_y, r_x_total,
                                     r_y_base, r_u_base, r_v_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_plane       <= PL_Y;
            r_row         <= '0;
            r_beat        <= 1'b0;
            r_mb_x        <= '0;
            r_mb_y        <= '0;
            r_x_total     <= '0;
            r_y_base      <= '0;
            r_u_base      <= '0;
            r_v_base      <= '0;
            load_done_o   <= 1'b0;
            rd_req_o      <= 1'b0;
            rd_addr_o     <= '0;
            rd_beats_o    <= '0;
            buf_wr_en_o   <= 1'b0;
            buf_wr_addr_o <= '0;
            buf_wr_data_o <= '0;
        end else begin
            buf_wr_en_o <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_start_i) begin
                        r_mb_x      <= mb_x_i;
                        r_mb_y      <= mb_y_i;
                        r_x_total   <= sys_x_total_i;
                        r_y_base    <= y_base_i;
                        r_u_base    <= u_base_i;
                        r_v_base    <= v_base_i;
                        r_plane     <= PL_Y;
                        r_row       <= '0;
                        r_beat      <= 1'b0;
                        load_done_o <= 1'b0;
                        rd_req_o    <= 1'b1;
                        rd_addr_o   <= w_start_addr;
                        rd_beats_o  <= 2'd2;
                        r_state     <= S_REQ;
                    end else if (r_state == S_DONE) begin
                        // Done lags the DONE state by one cycle so it follows the final write strobe.
                        load_done_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (rd_ack_i) begin
                        rd_req_o <= 1'b0;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_valid_i) begin
                        buf_wr_en_o   <= 1'b1;
                        buf_wr_addr_o <= w_wr_addr;
                        buf_wr_data_o <= rd_data_i;
                        r_beat        <= w_last_beat ? 1'b0 : r_beat + 1'b1;
                        if (w_last_beat) begin
                            if (w_fin) begin
                                r_state <= S_DONE;
                            end else begin
                                r_plane    <= w_nxt_plane;
                                r_row      <= w_nxt_row;
                                rd_req_o   <= 1'b1;
                                rd_addr_o  <= w_nxt_addr;
                                rd_beats_o <= (w_nxt_plane == PL_Y) ? 2'd2 : 2'd1;
                                r_state    <= S_REQ;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cur_mb_loader.sv
// Bench for cur_mb_loader: memory responder, per-cycle model comparison and
// directed macroblock scenarios with hand-computed anchor values.
module tb_cur_mb_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start_i = 1'b0;
    logic [7:0]  mb_x_i = '0, mb_y_i = '0, sys_x_total_i = '0;
    logic [31:0] y_base_i = '0, u_base_i = '0, v_base_i = '0;
    logic        rd_ack_i = 1'b0, rd_valid_i = 1'b0;
    logic [63:0] rd_data_i = '0;
    logic        load_done_o, rd_req_o, buf_wr_en_o;
    logic [31:0] rd_addr_o;
    logic [1:0]  rd_beats_o;
    logic [5:0]  buf_wr_addr_o;
    logic [63:0] buf_wr_data_o;

    always #5 clk = ~clk;

    cur_mb_loader #(.PIC_W_MB_LEN(8), .PIC_H_MB_LEN(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_start_i(load_start_i),
        .mb_x_i(mb_x_i), .mb_y_i(mb_y_i), .sys_x_total_i(sys_x_total_i),
        .y_base_i(y_base_i), .u_base_i(u_base_i), .v_base_i(v_base_i),
        .load_done_o(load_done_o), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
        .rd_beats_o(rd_beats_o), .rd_ack_i(rd_ack_i), .rd_valid_i(rd_valid_i),
        .rd_data_i(rd_data_i), .buf_wr_en_o(buf_wr_en_o),
        .buf_wr_addr_o(buf_wr_addr_o), .buf_wr_data_o(buf_wr_data_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame memory contents: a fixed hash of the byte address.
    function automatic logic [7:0] px(input logic [31:0] a);
        return a[7:0] ^ {a[10:8], a[15:11]} ^ (a[23:16] + 8'h5A) ^ a[31:24];
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = px(a + 32'(i));
        return w;
    endfunction

    function automatic logic [31:0] row_addr(input int p, input int r, input logic [7:0] mx,
                                             input logic [7:0] my, input logic [7:0] xt,
                                             input logic [31:0] base);
        logic [31:0] s;
        s = (p == 0) ? 32'd16 : 32'd8;
        return base + (32'(my) * s + 32'(r)) * ((32'(xt) + 32'd1) * s) + 32'(mx) * s;
    endfunction

    typedef struct { logic [31:0] a; logic [1:0] beats; } req_t;
    typedef struct { logic [5:0] a; logic [63:0] d; } wr_t;
    req_t exp_req[$];
    wr_t  exp_wr[$];

    task automatic build_model();
        req_t rq;
        wr_t  wr;
        logic [31:0] base;
        for (int p = 0; p < 3; p++) begin
            base = (p == 0) ? y_base_i : (p == 1) ? u_base_i : v_base_i;
            for (int r = 0; r < ((p == 0) ? 16 : 8); r++) begin
                rq.a     = row_addr(p, r, mb_x_i, mb_y_i, sys_x_total_i, base);
                rq.beats = (p == 0) ? 2'd2 : 2'd1;
                exp_req.push_back(rq);
                for (int b = 0; b < ((p == 0) ? 2 : 1); b++) begin
                    wr.a = (p == 0) ? 6'(2 * r + b) : 6'(32 + 8 * (p - 1) + r);
                    wr.d = mem_word(rq.a + 32'(8 * b));
                    exp_wr.push_back(wr);
                end
            end
        end
    endtask

    // Per-cycle comparison against the model (sampled on the falling edge).
    bit          mon_en = 1'b0, busy = 1'b0, armed = 1'b0, prev_req = 1'b0;
    logic [31:0] held_a;
    logic [1:0]  held_b;
    req_t        cur_rq;
    wr_t         cur_wr;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("reset_ctl", {21'b0, load_done_o, rd_req_o, rd_beats_o, buf_wr_en_o,
                                  buf_wr_addr_o, rd_addr_o}, 64'd0);
                chk("reset_data", buf_wr_data_o, 64'd0);
                exp_req.delete();
                exp_wr.delete();
                busy = 1'b0; armed = 1'b0; prev_req = 1'b0;
            end else begin
                chk("load_done", 64'(load_done_o), 64'(armed));
                if (buf_wr_en_o) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_write: got addr %0d expected no write", buf_wr_addr_o);
                    end else begin
                        cur_wr = exp_wr.pop_front();
                        chk("wr_addr", 64'(buf_wr_addr_o), 64'(cur_wr.a));
                        chk("wr_data", buf_wr_data_o, cur_wr.d);
                        if (exp_wr.size() == 0 && busy) begin busy = 1'b0; armed = 1'b1; end
                    end
                end
                if (rd_req_o) begin
                    if (!prev_req) begin
                        if (exp_req.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL extra_req: got addr %h expected no request", rd_addr_o);
                        end else begin
                            cur_rq = exp_req.pop_front();
                            chk("req_addr", 64'(rd_addr_o), 64'(cur_rq.a));
                            chk("req_beats", 64'(rd_beats_o), 64'(cur_rq.beats));
                        end
                        held_a = rd_addr_o;
                        held_b = rd_beats_o;
                    end else begin
                        chk("req_stable", 64'({rd_addr_o, rd_beats_o}), 64'({held_a, held_b}));
                    end
                end
                prev_req = rd_req_o;
                if (load_start_i && !busy) begin
                    busy = 1'b1; armed = 1'b0;
                    exp_req.delete();
                    exp_wr.delete();
                    build_model();
                end
            end
        end
    end

    // Memory responder: ack after ack_delay request cycles, then stream beats.
    int          ack_delay = 0;
    bit          gaps = 1'b0, spur = 1'b0;
    int          pend = 0, wcnt = 0, bidx = 0;
    logic [31:0] raddr = '0;

    initial forever begin
        @(posedge clk); #1;
        rd_ack_i = 1'b0;
        rd_valid_i = 1'b0;
        if (!rst_n) begin
            pend = 0; wcnt = 0;
        end else if (pend > 0) begin
            if (!gaps || $urandom_range(2) != 0) begin
                rd_valid_i = 1'b1;
                rd_data_i  = mem_word(raddr + 32'(8 * bidx));
                bidx++;
                pend--;
            end
        end else begin
            if (rd_req_o) begin
                if (wcnt >= ack_delay) begin
                    rd_ack_i = 1'b1;
                    raddr = rd_addr_o;
                    pend = int'(rd_beats_o);
                    bidx = 0; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            if (spur && $urandom_range(2) == 0) begin
                rd_valid_i = 1'b1;
                rd_data_i  = {$urandom, $urandom};
            end
        end
    end

    // One macroblock; zw = zero-wait memory so the cycle anchors apply.
    task automatic run_mb(input logic [7:0] mx, input logic [7:0] my, input logic [7:0] xt,
                          input logic [31:0] yb, input logic [31:0] ub, input logic [31:0] vb,
                          input int ad, input bit gp, input bit sp, input bit b2b, input bit zw,
                          input bit extra, input logic [31:0] a_first, input logic [31:0] a_u0,
                          input int rst_k);
        bit seen;
        ack_delay = ad; gaps = gp; spur = sp;
        if (b2b) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (load_done_o) seen = 1'b1;
                else begin @(posedge clk); #1; end
            end
            chk("b2b_done_wait", 64'(seen), 64'd1);
        end
        mb_x_i = mx; mb_y_i = my; sys_x_total_i = xt;
        y_base_i = yb; u_base_i = ub; v_base_i = vb;
        load_start_i = 1'b1;
        @(posedge clk); #1;
        load_start_i = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 3000 && !seen; k++) begin
            if (k == 1) begin
                chk("start_req", 64'(rd_req_o), 64'd1);
                chk("start_done_low", 64'(load_done_o), 64'd0);
                chk("first_addr", 64'(rd_addr_o), 64'(a_first));
                chk("first_beats", 64'(rd_beats_o), 64'd2);
            end
            if (zw && k == 49) begin
                chk("u0_addr", 64'(rd_addr_o), 64'(a_u0));
                chk("u0_beats", 64'(rd_beats_o), 64'd1);
            end
            if (extra && k == 4)  chk("y1_addr", 64'(rd_addr_o), 64'h1020);
            if (extra && k == 65) chk("v0_addr", 64'(rd_addr_o), 64'h3000);
            if (extra && k == 79) chk("v7_addr", 64'(rd_addr_o), 64'h3070);
            if (sp && k == 20) begin load_start_i = 1'b1; mb_x_i = 8'd77; end
            if (sp && k == 21) load_start_i = 1'b0;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst", {21'b0, load_done_o, rd_req_o, rd_beats_o, buf_wr_en_o,
                                  buf_wr_addr_o, rd_addr_o}, 64'd0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (load_done_o) begin
                seen = 1'b1;
                if (zw) chk("done_latency", 64'(k), 64'd82);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(load_done_o), 64'd0);
        chk("rst_req", 64'(rd_req_o), 64'd0);
        chk("rst_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_beats", 64'(rd_beats_o), 64'd0);
        chk("rst_wr_en", 64'(buf_wr_en_o), 64'd0);
        chk("rst_wr_addr", 64'(buf_wr_addr_o), 64'd0);
        chk("rst_wr_data", buf_wr_data_o, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_mb(8'd0, 8'd0, 8'd1, 32'h1000, 32'h2000, 32'h3000, 0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, 0);
        run_mb(8'd1, 8'd1, 8'd1, 32'h1000, 32'h2000, 32'h3000, 0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 32'h1210, 32'h2088, 0);
        run_mb(8'd255, 8'd255, 8'd255, 32'hFF10_0000, 32'h8000_0000, 32'hC000_0000, 0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 32'h000F_0FF0, 32'h803F_C7F8, 0);
        run_mb(8'd5, 8'd3, 8'd9, 32'h0040_0000, 32'h0050_0000, 32'h0058_0000, 3, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0, 32'h0040_1E50, 32'h0, 0);
        run_mb(8'd0, 8'd0, 8'd1, 32'h1000, 32'h2000, 32'h3000, 0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 32'h1000, 32'h2000, 56);
        run_mb(8'd2, 8'd0, 8'd3, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 32'h0001_0020, 32'h0002_0010, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("left_req", 64'(exp_req.size()), 64'd0);
        chk("left_wr", 64'(exp_wr.size()), 64'd0);
        chk("final_done", 64'(load_done_o), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
